// File: rtl/sync_timing_tracker_pkg.sv
// Shared types and default VGA 640x480 timing for the sync timing tracker.
package sync_timing_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } lock_state_t;

  localparam int unsigned VGA_TOTAL_COLS  = 800;
  localparam int unsigned VGA_TOTAL_ROWS  = 525;
  localparam int unsigned VGA_ACTIVE_COLS = 640;
  localparam int unsigned VGA_ACTIVE_ROWS = 480;

endpackage

// File: rtl/sync_timing_tracker_if.sv
// Sync inputs and recovered position/qualifier outputs of the tracker.
interface sync_timing_tracker_if #(
  parameter int unsigned COL_W = 10,
  parameter int unsigned ROW_W = 10
);
  logic             i_hsync;
  logic             i_vsync;
  logic             o_hsync;
  logic             o_vsync;
  logic [COL_W-1:0] o_col_counter;
  logic [ROW_W-1:0] o_row_counter;
  logic             o_active;
  logic             o_frame_start;
  logic             o_locked;
  logic             o_frame_err;

  modport master (
    output i_hsync, i_vsync,
    input  o_hsync, o_vsync, o_col_counter, o_row_counter,
           o_active, o_frame_start, o_locked, o_frame_err
  );

  modport slave (
    input  i_hsync, i_vsync,
    output o_hsync, o_vsync, o_col_counter, o_row_counter,
           o_active, o_frame_start, o_locked, o_frame_err
  );
endinterface

// File: rtl/sync_timing_tracker_lock_fsm.sv
// Frame-length lock tracker: acquires after LOCK_FRAMES good frames, drops on any bad one.
module sync_lock_fsm
  import sync_timing_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic rise,
  input  logic good,
  input  logic bad,
  output logic o_locked,
  output logic o_frame_err,
  output logic next_locked
);

  lock_state_t state, state_next;
  logic [3:0]  count, count_next, count_inc;
  logic        err_next;

  assign count_inc = count + 4'd1;

  always_comb begin
    state_next = state;
    count_next = count;
    err_next   = 1'b0;
    case (state)
      UNLOCKED: begin
        if (rise) begin
          state_next = ACQUIRE;
          count_next = '0;
        end
      end
      ACQUIRE: begin
        if (good) begin
          count_next = count_inc;
          if (count_inc == 4'(LOCK_FRAMES)) state_next = LOCKED;
        end else if (bad) begin
          count_next = '0;
        end
      end
      LOCKED: begin
        if (bad) begin
          state_next = UNLOCKED;
          err_next   = 1'b1;
        end
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= UNLOCKED;
      count       <= '0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      o_frame_err <= err_next;
    end
  end

  assign o_locked    = (state == LOCKED);
  assign next_locked = (state_next == LOCKED);

endmodule

// File: rtl/sync_timing_tracker.sv
// Recovers column/row position from hsync/vsync and qualifies it with lock/active/frame-start.
module sync_timing_tracker
  import sync_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS  = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS  = VGA_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS = VGA_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = VGA_ACTIVE_ROWS,
  parameter int unsigned COL_W       = 10,
  parameter int unsigned ROW_W       = 10,
  parameter bit          SYNC_POL    = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic                   clk,
  input logic                   i_rst_n,
  sync_timing_tracker_if.slave  bus
);

  logic             vs_n, vs_prev, rise;
  logic             col_last, row_last, frame_end, good, bad;
  logic [COL_W-1:0] col, col_next;
  logic [ROW_W-1:0] row, row_next;
  logic             locked_next;

  assign vs_n      = (bus.i_vsync == SYNC_POL);
  assign rise      = vs_n & ~vs_prev;
  assign col_last  = (col == COL_W'(TOTAL_COLS - 1));
  assign row_last  = (row == ROW_W'(TOTAL_ROWS - 1));
  assign frame_end = col_last & row_last;
  assign good      = rise & frame_end;
  assign bad       = rise ^ frame_end;

  always_comb begin
    col_next = col + COL_W'(1);
    row_next = row;
    if (rise) begin
      col_next = '0;
      row_next = '0;
    end else if (col_last) begin
      col_next = '0;
      row_next = row_last ? '0 : row + ROW_W'(1);
    end
  end

  sync_lock_fsm #(
    .LOCK_FRAMES(LOCK_FRAMES)
  ) u_lock (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .rise        (rise),
    .good        (good),
    .bad         (bad),
    .o_locked    (bus.o_locked),
    .o_frame_err (bus.o_frame_err),
    .next_locked (locked_next)
  );

  // o_active is built from next-state counters/lock so it lines up with the registered counters.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_prev           <= 1'b0;
      col               <= '0;
      row               <= '0;
      bus.o_hsync       <= 1'b0;
      bus.o_vsync       <= 1'b0;
      bus.o_frame_start <= 1'b0;
      bus.o_active      <= 1'b0;
    end else begin
      vs_prev           <= vs_n;
      col               <= col_next;
      row               <= row_next;
      bus.o_hsync       <= bus.i_hsync;
      bus.o_vsync       <= bus.i_vsync;
      bus.o_frame_start <= rise;
      bus.o_active      <= locked_next && (col_next < COL_W'(ACTIVE_COLS))
                                       && (row_next < ROW_W'(ACTIVE_ROWS));
    end
  end

  assign bus.o_col_counter = col;
  assign bus.o_row_counter = row;

endmodule
